// File: rtl/mem_pkg.sv
// Shared op codes, access sizes, FSM state codes and op decode helpers
// for the data-side memory access unit.
package mem_pkg;

   localparam logic [3:0] OP_LB  = 4'd0;
   localparam logic [3:0] OP_LBU = 4'd1;
   localparam logic [3:0] OP_LH  = 4'd2;
   localparam logic [3:0] OP_LHU = 4'd3;
   localparam logic [3:0] OP_LW  = 4'd4;
   localparam logic [3:0] OP_LWU = 4'd5;
   localparam logic [3:0] OP_LD  = 4'd6;
   localparam logic [3:0] OP_SB  = 4'd8;
   localparam logic [3:0] OP_SH  = 4'd9;
   localparam logic [3:0] OP_SW  = 4'd10;
   localparam logic [3:0] OP_SD  = 4'd11;

   // Access size as log2 of the byte count, matching the bus_size encoding
   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;
   localparam logic [1:0] SIZE_D = 2'd3;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_REQ   = 3'd1;
   localparam logic [2:0] ST_WAIT  = 3'd2;
   localparam logic [2:0] ST_DONE  = 3'd3;
   localparam logic [2:0] ST_DRAIN = 3'd4;

   function automatic logic is_store(input logic [3:0] op);
      return op[3];
   endfunction

   // Undefined op codes fall into the doubleword bucket
   function automatic logic [1:0] op_size(input logic [3:0] op);
      case (op)
         OP_LB, OP_LBU, OP_SB: return SIZE_B;
         OP_LH, OP_LHU, OP_SH: return SIZE_H;
         OP_LW, OP_LWU, OP_SW: return SIZE_W;
         default:              return SIZE_D;
      endcase
   endfunction

   function automatic logic is_unsigned(input logic [3:0] op);
      return (op == OP_LBU) || (op == OP_LHU) || (op == OP_LWU);
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane formatter: byte strobes and replicated store data on
// the way out, shifted and extended load data on the way back, plus the
// alignment check for the op at the given lane.
module mem_lane_align
   import mem_pkg::*;
#(
   parameter int DATA_W = 32,
   localparam int STRB_W = DATA_W / 8,
   localparam int LANE_W = $clog2(STRB_W)
) (
   input  logic [3:0]        op,
   input  logic [LANE_W-1:0] lane,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] rdata,
   output logic [STRB_W-1:0] wstrb,
   output logic [DATA_W-1:0] wdata_rep,
   output logic [DATA_W-1:0] rdata_ext,
   output logic              misalign
);

   logic [1:0]        size;
   logic [DATA_W-1:0] shifted;
   logic [DATA_W-1:0] sign_mask;
   logic              sign_bit;

   assign size    = op_size(op);
   assign shifted = rdata >> {lane, 3'b000};

   // Strobes cover the addressed bytes; store data is copied into every lane
   always_comb begin
      wstrb     = '1;
      wdata_rep = wdata;
      case (size)
         SIZE_B: begin
            wstrb     = STRB_W'(1) << lane;
            wdata_rep = {STRB_W{wdata[7:0]}};
         end
         SIZE_H: begin
            wstrb     = STRB_W'(3) << lane;
            wdata_rep = {(STRB_W / 2){wdata[15:0]}};
         end
         SIZE_W: begin
            wstrb     = STRB_W'(15) << lane;
            wdata_rep = {(STRB_W / 4){wdata[31:0]}};
         end
         default: begin
            wstrb     = '1;
            wdata_rep = wdata;
         end
      endcase
   end

   // Wider-than-bus ops (LWU, LD, SD on a 32-bit build) are reported as misaligned
   always_comb begin
      case (size)
         SIZE_H:  misalign = lane[0];
         SIZE_W:  misalign = (lane[1:0] != 2'b00);
         SIZE_D:  misalign = (DATA_W == 32) || (lane != '0);
         default: misalign = 1'b0;
      endcase
      if ((DATA_W == 32) && (op == OP_LWU)) begin
         misalign = 1'b1;
      end
   end

   // Right-align the loaded bytes, then OR in the sign mask for signed loads
   always_comb begin
      rdata_ext = shifted;
      sign_mask = '0;
      sign_bit  = 1'b0;
      case (size)
         SIZE_B: begin
            rdata_ext = DATA_W'(shifted[7:0]);
            sign_bit  = shifted[7];
            sign_mask = {DATA_W{1'b1}} << 8;
         end
         SIZE_H: begin
            rdata_ext = DATA_W'(shifted[15:0]);
            sign_bit  = shifted[15];
            sign_mask = {DATA_W{1'b1}} << 16;
         end
         SIZE_W: begin
            rdata_ext = DATA_W'(shifted[31:0]);
            sign_bit  = shifted[31];
            sign_mask = {DATA_W{1'b1}} << 32;
         end
         default: begin
            rdata_ext = shifted;
         end
      endcase
      if (!is_unsigned(op) && sign_bit) begin
         rdata_ext = rdata_ext | sign_mask;
      end
   end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access unit: accepts one load/store from the M stage, checks
// alignment, runs a single outstanding transaction on the address/data
// handshake bus and returns formatted load data or a store completion.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  req_valid,
   input  logic [3:0]            req_op,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   input  logic                  req_kill,
   output logic                  stall,
   output logic                  resp_valid,
   output logic [DATA_W-1:0]     resp_rdata,
   output logic                  adel,
   output logic                  ades,
   output logic [ADDR_W-1:0]     bad_addr,
   output logic                  bus_req,
   output logic                  bus_wr,
   output logic [1:0]            bus_size,
   output logic [ADDR_W-1:0]     bus_addr,
   output logic [DATA_W/8-1:0]   bus_wstrb,
   output logic [DATA_W-1:0]     bus_wdata,
   input  logic                  bus_addr_ok,
   input  logic                  bus_data_ok,
   input  logic [DATA_W-1:0]     bus_rdata
);

   localparam int STRB_W = DATA_W / 8;
   localparam int LANE_W = $clog2(STRB_W);

   logic [2:0]        state;
   logic [2:0]        state_nxt;
   logic [3:0]        op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              fault_q;
   logic [DATA_W-1:0] rdata_q;
   logic [ADDR_W-1:0] bad_addr_q;

   logic              idle;
   logic              accept;
   logic              capture;
   logic [3:0]        al_op;
   logic [LANE_W-1:0] al_lane;
   logic [DATA_W-1:0] al_wdata;
   logic [STRB_W-1:0] al_wstrb;
   logic [DATA_W-1:0] al_wdata_rep;
   logic [DATA_W-1:0] al_rdata_ext;
   logic              al_misalign;

   assign idle   = (state == ST_IDLE);
   assign accept = idle && req_valid && !req_kill;

   // The formatter sees the incoming op while idle (for the alignment check)
   // and the latched op otherwise, so bus outputs hold steady until accepted.
   assign al_op    = idle ? req_op : op_q;
   assign al_lane  = idle ? req_addr[LANE_W-1:0] : addr_q[LANE_W-1:0];
   assign al_wdata = idle ? req_wdata : wdata_q;

   mem_lane_align #(
      .DATA_W(DATA_W)
   ) u_align (
      .op        (al_op),
      .lane      (al_lane),
      .wdata     (al_wdata),
      .rdata     (bus_rdata),
      .wstrb     (al_wstrb),
      .wdata_rep (al_wdata_rep),
      .rdata_ext (al_rdata_ext),
      .misalign  (al_misalign)
   );

   // Next-state logic; a kill that coincides with returning data still
   // cancels the op, and a kill with addr_ok alone must drain the response.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_nxt = al_misalign ? ST_DONE : ST_REQ;
            end
         end
         ST_REQ: begin
            if (bus_addr_ok && bus_data_ok) begin
               state_nxt = req_kill ? ST_IDLE : ST_DONE;
            end else if (bus_addr_ok) begin
               state_nxt = req_kill ? ST_DRAIN : ST_WAIT;
            end else if (req_kill) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (bus_data_ok) begin
               state_nxt = req_kill ? ST_IDLE : ST_DONE;
            end else if (req_kill) begin
               state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (bus_data_ok) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign capture = (state_nxt == ST_DONE) && ((state == ST_REQ) || (state == ST_WAIT));

   // State, latched request, registered response data and sticky fault address
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= ST_IDLE;
         op_q       <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         fault_q    <= 1'b0;
         rdata_q    <= '0;
         bad_addr_q <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            op_q    <= req_op;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            fault_q <= al_misalign;
            rdata_q <= '0;
            if (al_misalign) begin
               bad_addr_q <= req_addr;
            end
         end
         if (capture) begin
            rdata_q <= is_store(op_q) ? '0 : al_rdata_ext;
         end
      end
   end

   // Stall is forced low while reset is held so the pipeline never sees it
   assign stall      = resetn && req_valid && (state != ST_DONE);
   assign resp_valid = (state == ST_DONE);
   assign resp_rdata = rdata_q;
   assign adel       = resp_valid && fault_q && !is_store(op_q);
   assign ades       = resp_valid && fault_q && is_store(op_q);
   assign bad_addr   = bad_addr_q;

   assign bus_req   = (state == ST_REQ);
   assign bus_wr    = is_store(op_q);
   assign bus_size  = op_size(op_q);
   assign bus_addr  = {addr_q[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
   assign bus_wstrb = al_wstrb;
   assign bus_wdata = al_wdata_rep;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a 32-bit and a 64-bit instance share
// stimulus; a vector table covers formatting, strobes, faults and wait
// states, and hand-written sequences cover kill, drain and async reset.
module tb_mem_access_unit;

   localparam logic [3:0] L_LB  = 4'd0;
   localparam logic [3:0] L_LBU = 4'd1;
   localparam logic [3:0] L_LH  = 4'd2;
   localparam logic [3:0] L_LHU = 4'd3;
   localparam logic [3:0] L_LW  = 4'd4;
   localparam logic [3:0] L_LWU = 4'd5;
   localparam logic [3:0] L_LD  = 4'd6;
   localparam logic [3:0] L_SB  = 4'd8;
   localparam logic [3:0] L_SH  = 4'd9;
   localparam logic [3:0] L_SW  = 4'd10;
   localparam logic [3:0] L_SD  = 4'd11;
   localparam logic [63:0] RD32 = 64'h0000_0000_80FF_7F01;

   typedef struct {
      string       name;
      bit          wide;
      logic [3:0]  op;
      logic [31:0] addr;
      logic [63:0] wdata;
      logic [63:0] rdata;
      int          aw;
      int          dw;
      int          lat;
      logic [63:0] exp_rdata;
      bit          exp_adel;
      bit          exp_ades;
      bit          exp_bus;
      bit          chk_w;
      logic [7:0]  exp_wstrb;
      logic [63:0] exp_wdata;
   } vec_t;

   logic        clk;
   logic        resetn;
   logic [3:0]  req_op;
   logic [31:0] req_addr;
   logic [63:0] req_wdata;
   logic        req_kill;
   logic        bus_addr_ok;
   logic        bus_data_ok;
   logic [63:0] bus_rdata;

   logic        n_req_valid, n_stall, n_resp_valid, n_adel, n_ades, n_bus_req, n_bus_wr;
   logic [31:0] n_resp_rdata, n_bad_addr, n_bus_addr, n_bus_wdata;
   logic [1:0]  n_bus_size;
   logic [3:0]  n_bus_wstrb;

   logic        w_req_valid, w_stall, w_resp_valid, w_adel, w_ades, w_bus_req, w_bus_wr;
   logic [63:0] w_resp_rdata, w_bus_wdata;
   logic [31:0] w_bad_addr, w_bus_addr;
   logic [1:0]  w_bus_size;
   logic [7:0]  w_bus_wstrb;

   int checks = 0;
   int failures = 0;
   vec_t vecs[$];

   mem_access_unit #(.DATA_W(32), .ADDR_W(32)) dut32 (
      .clk(clk), .resetn(resetn), .req_valid(n_req_valid), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata[31:0]), .req_kill(req_kill),
      .stall(n_stall), .resp_valid(n_resp_valid), .resp_rdata(n_resp_rdata),
      .adel(n_adel), .ades(n_ades), .bad_addr(n_bad_addr), .bus_req(n_bus_req),
      .bus_wr(n_bus_wr), .bus_size(n_bus_size), .bus_addr(n_bus_addr),
      .bus_wstrb(n_bus_wstrb), .bus_wdata(n_bus_wdata), .bus_addr_ok(bus_addr_ok),
      .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata[31:0])
   );

   mem_access_unit #(.DATA_W(64), .ADDR_W(32)) dut64 (
      .clk(clk), .resetn(resetn), .req_valid(w_req_valid), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_kill(req_kill),
      .stall(w_stall), .resp_valid(w_resp_valid), .resp_rdata(w_resp_rdata),
      .adel(w_adel), .ades(w_ades), .bad_addr(w_bad_addr), .bus_req(w_bus_req),
      .bus_wr(w_bus_wr), .bus_size(w_bus_size), .bus_addr(w_bus_addr),
      .bus_wstrb(w_bus_wstrb), .bus_wdata(w_bus_wdata), .bus_addr_ok(bus_addr_ok),
      .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   task automatic check_quiet_outputs(input string tag, input bit wide);
      if (wide) begin
         check_output({tag, ".bus_req"}, 64'(w_bus_req), 64'h0);
         check_output({tag, ".stall"}, 64'(w_stall), 64'h0);
         check_output({tag, ".resp_valid"}, 64'(w_resp_valid), 64'h0);
         check_output({tag, ".adel_ades"}, 64'({w_adel, w_ades}), 64'h0);
         check_output({tag, ".bad_addr"}, 64'(w_bad_addr), 64'h0);
         check_output({tag, ".resp_rdata"}, w_resp_rdata, 64'h0);
      end else begin
         check_output({tag, ".bus_req"}, 64'(n_bus_req), 64'h0);
         check_output({tag, ".stall"}, 64'(n_stall), 64'h0);
         check_output({tag, ".resp_valid"}, 64'(n_resp_valid), 64'h0);
         check_output({tag, ".adel_ades"}, 64'({n_adel, n_ades}), 64'h0);
         check_output({tag, ".bad_addr"}, 64'(n_bad_addr), 64'h0);
         check_output({tag, ".resp_rdata"}, 64'(n_resp_rdata), 64'h0);
      end
   endtask

   // Presents one op, answers the bus after aw/dw wait cycles and checks the result
   task automatic apply_stimulus(input vec_t v);
      int          lat;
      bit          seen_bus, unstable, stall_bad;
      logic        s_req, s_stall, s_resp, s_wr, wr0;
      logic [31:0] s_addr, a0, r_bad, exp_baddr;
      logic [7:0]  s_strb, strb0;
      logic [63:0] s_wdata, wdata0, r_rdata;
      logic        r_adel, r_ades;
      lat = -1; seen_bus = 0; unstable = 0; stall_bad = 0;
      a0 = '0; strb0 = '0; wdata0 = '0; wr0 = 1'b0;
      r_rdata = '0; r_adel = 1'b0; r_ades = 1'b0; r_bad = '0;
      @(negedge clk);
      req_op = v.op; req_addr = v.addr; req_wdata = v.wdata; bus_rdata = v.rdata;
      req_kill = 1'b0;
      n_req_valid = !v.wide; w_req_valid = v.wide;
      for (int c = 0; c < 30 && lat < 0; c++) begin
         if (c > 0) @(negedge clk);
         bus_addr_ok = (c == 1 + v.aw);
         bus_data_ok = (c == 1 + v.aw + v.dw);
         #1;
         if (v.wide) begin
            s_req = w_bus_req; s_stall = w_stall; s_resp = w_resp_valid; s_wr = w_bus_wr;
            s_addr = w_bus_addr; s_strb = w_bus_wstrb; s_wdata = w_bus_wdata;
         end else begin
            s_req = n_bus_req; s_stall = n_stall; s_resp = n_resp_valid; s_wr = n_bus_wr;
            s_addr = n_bus_addr; s_strb = {4'b0, n_bus_wstrb}; s_wdata = {32'b0, n_bus_wdata};
         end
         if (s_req) begin
            if (!seen_bus) begin
               a0 = s_addr; strb0 = s_strb; wdata0 = s_wdata; wr0 = s_wr;
            end else if ({s_addr, s_strb, s_wdata, s_wr} != {a0, strb0, wdata0, wr0}) begin
               unstable = 1;
            end
            seen_bus = 1;
         end
         if (s_stall == s_resp) stall_bad = 1;
         if (s_resp) begin
            lat = c;
            if (v.wide) begin
               r_rdata = w_resp_rdata; r_adel = w_adel; r_ades = w_ades; r_bad = w_bad_addr;
            end else begin
               r_rdata = {32'b0, n_resp_rdata}; r_adel = n_adel; r_ades = n_ades; r_bad = n_bad_addr;
            end
         end
      end
      n_req_valid = 1'b0; w_req_valid = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
      check_output({v.name, ".latency"}, 64'(lat), 64'(v.lat));
      check_output({v.name, ".rdata"}, r_rdata, v.exp_rdata);
      check_output({v.name, ".adel"}, 64'(r_adel), 64'(v.exp_adel));
      check_output({v.name, ".ades"}, 64'(r_ades), 64'(v.exp_ades));
      check_output({v.name, ".bus_used"}, 64'(seen_bus), 64'(v.exp_bus));
      check_output({v.name, ".stall"}, 64'(stall_bad), 64'h0);
      if (v.exp_adel || v.exp_ades) begin
         check_output({v.name, ".bad_addr"}, 64'(r_bad), 64'(v.addr));
      end
      if (v.exp_bus) begin
         exp_baddr = v.addr & (v.wide ? 32'hFFFF_FFF8 : 32'hFFFF_FFFC);
         check_output({v.name, ".bus_addr"}, 64'(a0), 64'(exp_baddr));
         check_output({v.name, ".bus_wr"}, 64'(wr0), 64'(v.op[3]));
         check_output({v.name, ".bus_stable"}, 64'(unstable), 64'h0);
      end
      if (v.chk_w) begin
         check_output({v.name, ".wstrb"}, 64'(strb0), 64'(v.exp_wstrb));
         check_output({v.name, ".wdata"}, wdata0, v.exp_wdata);
      end
   endtask

   // Global guard so a stuck sequence still ends the run
   initial begin
      #400000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t v;
      resetn = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0; req_kill = 1'b0;
      bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
      n_req_valid = 1'b0; w_req_valid = 1'b0;

      //            name        wide  op     addr          wdata                   rdata                   aw dw lat exp_rdata               adel  ades  bus   chk_w strb   exp_wdata
      vecs.push_back('{"lb_l0",  1'b0, L_LB,  32'h0,        64'h0,                  RD32,                   0, 0, 2, 64'h0000_0001,         1'b0, 1'b0, 1'b1, 1'b0, 8'h0,  64'h0});
      vecs.push_back('{"lb_l1",  1'b0, L_LB,  32'h1,        64'h0,                  RD32,                   0, 0, 2, 64'h0000_007F,         1'b0, 1'b0, 1'b1, 1'b0, 8'h0,  64'h0});
      vecs.push_back('{"lb_l2",  1'b0, L_LB,  32'h2,        64'h0,                  RD32,                   0, 0, 2, 64'hFFFF_FFFF,         1'b0, 1'b0, 1'b1, 1'b0, 8'h0,  64'h0});
      vecs.push_back('{"lb_l3",  1'b0, L_LB,  32'h3,        64'h0,                  RD32,                   0, 0, 2, 64'hFFFF_FF80,         1'b0, 1'b0, 1'b1, 1'b0, 8'h0,  64'h0});
      vecs.push_back('{"lbu_l3", 1'b0, L_LBU, 32'h3,        64'h0,                  RD32,                   0, 0, 2, 64'h0000_0080,         1'b0, 1'b0, 1'b1, 1'b0, 8'h0,  64'h0});
      vecs.push_back('{"lh_l2",  1'b0, L_LH,  32'h2,        64'h0,                  RD32,                   0, 0, 2, 64'hFFFF_80FF,         1'b0, 1'b0, 1'b1, 1'b0, 8'h0,  64'h0});
      vecs.push_back('{"lhu_l0", 1'b0, L_LHU, 32'h0,        64'h0,                  RD32,                   0, 0, 2, 64'h0000_7F01,         1'b0, 1'b0, 1'b1, 1'b0, 8'h0,  64'h0});
      vecs.push_back('{"lw32",   1'b0, L_LW,  32'h100,      64'h0,                  RD32,                   0, 0, 2, 64'h80FF_7F01,         1'b0, 1'b0, 1'b1, 1'b0, 8'h0,  64'h0});
      vecs.push_back('{"sb_l2",  1'b0, L_SB,  32'h1002,     64'hAB,                 RD32,                   0, 0, 2, 64'h0,                 1'b0, 1'b0, 1'b1, 1'b1, 8'h04, 64'hABAB_ABAB});
      vecs.push_back('{"sh_l2",  1'b0, L_SH,  32'h2,        64'h1234,               RD32,                   0, 0, 2, 64'h0,                 1'b0, 1'b0, 1'b1, 1'b1, 8'h0C, 64'h1234_1234});
      vecs.push_back('{"sw32",   1'b0, L_SW,  32'h4,        64'hDEAD_BEEF,          RD32,                   0, 0, 2, 64'h0,                 1'b0, 1'b0, 1'b1, 1'b1, 8'h0F, 64'hDEAD_BEEF});
      vecs.push_back('{"lw_mis", 1'b0, L_LW,  32'h1001,     64'h0,                  RD32,                   0, 0, 1, 64'h0,                 1'b1, 1'b0, 1'b0, 1'b0, 8'h0,  64'h0});
      vecs.push_back('{"sh_mis", 1'b0, L_SH,  32'h3,        64'h55,                 RD32,                   0, 0, 1, 64'h0,                 1'b0, 1'b1, 1'b0, 1'b0, 8'h0,  64'h0});
      vecs.push_back('{"lwu32",  1'b0, L_LWU, 32'h0,        64'h0,                  RD32,                   0, 0, 1, 64'h0,                 1'b1, 1'b0, 1'b0, 1'b0, 8'h0,  64'h0});
      vecs.push_back('{"ld32",   1'b0, L_LD,  32'h8,        64'h0,                  RD32,                   0, 0, 1, 64'h0,                 1'b1, 1'b0, 1'b0, 1'b0, 8'h0,  64'h0});
      vecs.push_back('{"lw_wait",1'b0, L_LW,  32'h20,       64'h0,                  RD32,                   3, 2, 7, 64'h80FF_7F01,         1'b0, 1'b0, 1'b1, 1'b0, 8'h0,  64'h0});
      vecs.push_back('{"sb_wait",1'b0, L_SB,  32'h1,        64'h5C,                 RD32,                   1, 1, 4, 64'h0,                 1'b0, 1'b0, 1'b1, 1'b1, 8'h02, 64'h5C5C_5C5C});
      vecs.push_back('{"ld64",   1'b1, L_LD,  32'h8,        64'h0,                  64'h0123_4567_89AB_CDEF, 0, 0, 2, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 64'h0});
      vecs.push_back('{"lwu64",  1'b1, L_LWU, 32'h4,        64'h0,                  64'h8000_0000_1234_5678, 0, 0, 2, 64'h0000_0000_8000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0,  64'h0});
      vecs.push_back('{"lw64",   1'b1, L_LW,  32'h4,        64'h0,                  64'h8000_0000_1234_5678, 0, 0, 2, 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0,  64'h0});
      vecs.push_back('{"lh64",   1'b1, L_LH,  32'h6,        64'h0,                  64'h8001_0000_0000_0000, 0, 1, 3, 64'hFFFF_FFFF_FFFF_8001, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0,  64'h0});
      vecs.push_back('{"sd64",   1'b1, L_SD,  32'h10,       64'h1122_3344_5566_7788, 64'h0,                 0, 0, 2, 64'h0,                 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 64'h1122_3344_5566_7788});
      vecs.push_back('{"sw64",   1'b1, L_SW,  32'h4,        64'hCAFE_F00D,          64'h0,                  0, 0, 2, 64'h0,                 1'b0, 1'b0, 1'b1, 1'b1, 8'hF0, 64'hCAFE_F00D_CAFE_F00D});
      vecs.push_back('{"sb64",   1'b1, L_SB,  32'h7,        64'h5A,                 64'h0,                  2, 0, 4, 64'h0,                 1'b0, 1'b0, 1'b1, 1'b1, 8'h80, 64'h5A5A_5A5A_5A5A_5A5A});
      vecs.push_back('{"ld_mis", 1'b1, L_LD,  32'hC,        64'h0,                  64'h0,                  0, 0, 1, 64'h0,                 1'b1, 1'b0, 1'b0, 1'b0, 8'h0,  64'h0});

      repeat (2) @(negedge clk);
      #1;
      check_quiet_outputs("reset32", 1'b0);
      check_quiet_outputs("reset64", 1'b1);
      @(negedge clk);
      resetn = 1'b1;

      foreach (vecs[i]) apply_stimulus(vecs[i]);

      // Kill while in REQ: request withdrawn, no response, unit idle next cycle
      $display("[TB] sequence: kill in REQ");
      @(negedge clk);
      req_op = L_LW; req_addr = 32'h0; n_req_valid = 1'b1;
      @(negedge clk);
      req_kill = 1'b1;
      #1 check_output("kill_req.bus_req", 64'(n_bus_req), 64'h1);
      @(negedge clk);
      req_kill = 1'b0; n_req_valid = 1'b0;
      #1 check_output("kill_req.idle_bus_req", 64'(n_bus_req), 64'h0);
      check_output("kill_req.resp", 64'(n_resp_valid), 64'h0);
      @(negedge clk);
      #1 check_output("kill_req.resp_late", 64'(n_resp_valid), 64'h0);

      // Kill while in WAIT: late data_ok is swallowed without a response
      $display("[TB] sequence: kill in WAIT");
      @(negedge clk);
      req_op = L_LW; req_addr = 32'h40; bus_rdata = RD32; n_req_valid = 1'b1;
      @(negedge clk);
      bus_addr_ok = 1'b1;
      #1 check_output("kill_wait.bus_req", 64'(n_bus_req), 64'h1);
      @(negedge clk);
      bus_addr_ok = 1'b0; req_kill = 1'b1;
      #1 check_output("kill_wait.wait_bus_req", 64'(n_bus_req), 64'h0);
      @(negedge clk);
      req_kill = 1'b0; n_req_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) @(negedge clk);
         bus_data_ok = (c == 1);
         #1 check_output($sformatf("kill_wait.no_resp%0d", c), 64'(n_resp_valid), 64'h0);
         check_output($sformatf("kill_wait.no_req%0d", c), 64'(n_bus_req), 64'h0);
      end
      bus_data_ok = 1'b0;
      v = '{"after_drain", 1'b0, L_LB, 32'h1, 64'h0, RD32, 0, 0, 2, 64'h0000_007F, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0, 64'h0};
      apply_stimulus(v);

      // Kill arriving in the DONE cycle does not suppress the response
      $display("[TB] sequence: kill in DONE");
      @(negedge clk);
      req_op = L_LBU; req_addr = 32'h2; n_req_valid = 1'b1;
      @(negedge clk);
      bus_addr_ok = 1'b1; bus_data_ok = 1'b1;
      @(negedge clk);
      bus_addr_ok = 1'b0; bus_data_ok = 1'b0; req_kill = 1'b1;
      #1 check_output("kill_done.resp", 64'(n_resp_valid), 64'h1);
      check_output("kill_done.rdata", 64'(n_resp_rdata), 64'h0000_00FF);
      @(negedge clk);
      req_kill = 1'b0; n_req_valid = 1'b0;

      // Async reset in the middle of a 64-bit WAIT clears outputs at once
      $display("[TB] sequence: async reset during WAIT");
      #1 check_output("rst_wait.bad_addr_before", 64'(w_bad_addr), 64'hC);
      @(negedge clk);
      req_op = L_LD; req_addr = 32'h8; bus_rdata = 64'h0123_4567_89AB_CDEF; w_req_valid = 1'b1;
      @(negedge clk);
      bus_addr_ok = 1'b1;
      @(negedge clk);
      bus_addr_ok = 1'b0;
      #1 check_output("rst_wait.stall_before", 64'(w_stall), 64'h1);
      #2 resetn = 1'b0;
      #1 check_quiet_outputs("rst_wait", 1'b1);
      @(negedge clk);
      w_req_valid = 1'b0;
      resetn = 1'b1;
      v = '{"after_reset", 1'b1, L_LD, 32'h18, 64'h0, 64'hFEDC_BA98_7654_3210, 0, 0, 2, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 64'h0};
      apply_stimulus(v);

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised memory-stage access unit for the MIPS core. It sits between the M stage and the data-side SRAM-like bus, which has an address/data handshake. It accepts one load/store per request and checks alignment, raising AdEL/AdES with the bad address. It issues a byte-strobed bus transaction, stalls the pipeline until the response returns, then returns sign- or zero-extended read data. This is the successor to fixed-32-bit, zero-wait-state byte/half/word formatting: it adds data width `DATA_W`, wait states, kill/drain handling and doubleword ops.

## Interface
- `DATA_W`, 32: bus and register data width; 32 or 64.
- `ADDR_W`, 32: address width.
- `clk`  in  1  single clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  M stage holds a memory op.
- `req_op`  in  4  op code: 0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWU, 6 LD, 8 SB, 9 SH, 10 SW, 11 SD; bit 3 means store.
- `req_addr`  in  ADDR_W  virtual/physical byte address (already mapped).
- `req_wdata`  in  DATA_W  store data, right-aligned.
- `req_kill`  in  1  exception/flush from the pipeline; cancels the accepted op.
- `stall`  out  1  holds the pipeline while an op is in flight.
- `resp_valid`  out  1  one-cycle pulse; load data or store completion.
- `resp_rdata`  out  DATA_W  extended load data; 0 for stores.
- `adel`, `ades`  out  1  address-error pulse, aligned with `resp_valid`.
- `bad_addr`  out  ADDR_W  faulting address; holds until the next fault.
- `bus_req`  out  1  request.
- `bus_wr`  out  1  write.
- `bus_size`  out  2  log2 of access bytes.
- `bus_addr`  out  ADDR_W  address aligned down to `DATA_W/8`.
- `bus_wstrb`  out  DATA_W/8  byte write strobes.
- `bus_wdata`  out  DATA_W  lane-replicated store data.
- `bus_addr_ok`  in  1  request accepted.
- `bus_data_ok`  in  1  response (read data or write ack).
- `bus_rdata`  in  DATA_W  read data.

## Operation
- **States:** IDLE, REQ, WAIT, DONE, DRAIN.
- **IDLE:**
  - `req_valid` & !`req_kill` latches op/addr/wdata.
  - If aligned, go to REQ.
  - If misaligned, go to DONE with the fault flag set; no bus request.
  - Misaligned means: half with addr[0]≠0; word with addr[1:0]≠0; double with addr[2:0]≠0.
  - LWU/LD/SD when `DATA_W`=32 count as misaligned.
- **REQ:**
  - `bus_req`=1, with `bus_*` driven from the latched registers.
  - `bus_addr_ok` & `bus_data_ok` in the same cycle → DONE.
  - `bus_addr_ok` alone → WAIT.
  - `req_kill` without `addr_ok` → IDLE; no response.
- **WAIT:**
  - `bus_data_ok` → DONE; capture the formatted `bus_rdata`.
  - `req_kill` → DRAIN.
- **DRAIN:** wait for `bus_data_ok`, discard the data, go to IDLE; no `resp_valid`.
- **DONE:**
  - `resp_valid`=1 for one cycle; `adel` (load) or `ades` (store) set if faulted, with `bad_addr` loaded.
  - Next state is IDLE.
- **Stall:** `stall` = `req_valid` & (state≠DONE). The op is re-presented each stall cycle; the unit ignores it while not in IDLE.
- **Lane mapping:** lane = addr[log2(DATA_W/8)-1:0].
  - Strobes: byte 1<<lane; half 3<<lane; word 4'hF<<lane; double all ones.
  - Store data is replicated across the lanes.
  - Load data is `bus_rdata`>>(8·lane), then sign- or zero-extended to `DATA_W`.
  - LW sign-extends on 64-bit builds.
- A kill that arrives in the DONE cycle is ignored; the response is already committed.

## Timing
- Reset: state IDLE, registers 0.
- Outputs in reset: `bus_req` 0, `stall` 0, `resp_valid` 0, `adel`/`ades` 0, `bad_addr` 0, `resp_rdata` 0.
- Reset mid-transaction abandons the transaction without draining; the bus is reset together with the unit.
- Latency:
  - Accept at cycle 0, REQ at cycle 1, minimum `resp_valid` at cycle 2.
  - Each `addr_ok`/`data_ok` wait cycle adds 1.
  - Misaligned op: `resp_valid` at cycle 1.
- `bus_*` stays stable from REQ entry until `bus_addr_ok`.
- Only one outstanding request is allowed.
- `resp_rdata` is registered and valid only with `resp_valid`.

## Structure
- `mem_pkg` holds:
  - op-code localparams and the `is_store`/`size` decode function;
  - the FSM state enum;
  - size encodings.
- Sub-module `mem_lane_align` is combinational:
  - inputs: op, lane, wdata, rdata;
  - outputs: wstrb, replicated wdata, extended rdata, misalign flag.
- It is instantiated once; the FSM and registers live in `mem_access_unit`.

## Test plan
- **LB/LBU lane sweep:** `DATA_W`=32, `bus_rdata`=32'h80FF7F01, addr 0..3.
  - LB → 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80.
  - LBU at lane 3 → 0x00000080.
  - Latency is 2 cycles with zero wait.
- **Store strobes:** SB addr 0x..2, data 0xAB → `bus_wstrb` 4'b0100, `bus_wdata` 0xABABABAB. SH addr 0x..2 → strobes 4'b1100.
- **Misalign:**
  - LW addr 0x1001 → `adel`=1 and `bad_addr`=0x1001 at cycle 1, `bus_req` never set.
  - SH addr 0x3 → `ades`=1.
- **Wait states:** `addr_ok` delayed 3 cycles, `data_ok` delayed 2 more.
  - `resp_valid` at cycle 7.
  - `stall` high on cycles 0–6.
  - `bus_*` stable while waiting.
- **Kill:**
  - Kill in REQ → no response, IDLE next cycle.
  - Kill in WAIT → DRAIN; the `data_ok` arriving 2 cycles later is consumed, no `resp_valid`.
  - A new op is then accepted normally.
- **64-bit mode:**
  - LD addr 0x8 → all strobes, full data.
  - LWU lane 4 with `bus_rdata`[63:32]=0x8000_0000 → 0x0000_0000_8000_0000.
  - Async reset mid-WAIT → all outputs 0 immediately.
